// File: rtl/spi_master_byte.sv
// SPI mode-0 byte master: MSB first, active-low SSEL held across multi-byte
// transactions until a byte flagged tx_last completes; each received byte strobes rx_valid.
module spi_master_byte #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 8,
  parameter int CS_HOLD  = 8,
  parameter int CS_IDLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_LOW       = 3'd2,
    ST_HIGH      = 3'd3,
    ST_WAIT_NEXT = 3'd4,
    ST_HOLD      = 3'd5,
    ST_GAP       = 3'd6
  } state_t;

  localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_END  = 16'(CS_IDLE - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  tx_sr;
  logic [6:0]  rx_sr;
  logic        last_q;
  logic        miso_meta, miso_s;
  logic        accept, bit_end, byte_end, timed;

  // Handshake: a byte transfers on any cycle where tx_valid && tx_ready;
  // tx_ready is high only while IDLE or WAIT_NEXT and never depends on tx_valid.
  assign tx_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT_NEXT);
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = (state_q == ST_HIGH) && (cnt == DIV_END);
  assign byte_end = bit_end && (bit_cnt == 3'd7);
  assign timed    = (state_q != ST_IDLE) && (state_q != ST_WAIT_NEXT);
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt     <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || !timed) cnt <= 16'd0;
      else cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (tx_valid) state_d = ST_SETUP;
      ST_SETUP:     if (cnt == SETUP_END) state_d = ST_LOW;
      ST_LOW:       if (cnt == DIV_END) state_d = ST_HIGH;
      ST_HIGH: begin
        if (bit_end) begin
          if (!byte_end) state_d = ST_LOW;
          else if (last_q) state_d = ST_HOLD;
          else state_d = ST_WAIT_NEXT;
        end
      end
      ST_WAIT_NEXT: if (tx_valid) state_d = ST_LOW;
      ST_HOLD:      if (cnt == HOLD_END) state_d = ST_GAP;
      ST_GAP:       if (cnt == IDLE_END) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      SCK       <= 1'b0;
      MOSI      <= 1'b0;
      SSEL      <= 1'b1;
      busy      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      tx_sr     <= 7'd0;
      rx_sr     <= 7'd0;
      last_q    <= 1'b0;
      bit_cnt   <= 3'd0;
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      miso_meta <= MISO;
      miso_s    <= miso_meta;
      SCK       <= (state_d == ST_HIGH);
      SSEL      <= (state_d == ST_IDLE) || (state_d == ST_GAP);
      busy      <= (state_d != ST_IDLE);
      rx_valid  <= byte_end;
      if (accept) begin
        tx_sr   <= tx_data[6:0];
        MOSI    <= tx_data[7];
        last_q  <= tx_last;
        bit_cnt <= 3'd0;
      end else if (bit_end) begin
        rx_sr   <= {rx_sr[5:0], miso_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_end) begin
          MOSI    <= 1'b0;
          rx_data <= {rx_sr, miso_s};
        end else begin
          MOSI  <= tx_sr[6];
          tx_sr <= {tx_sr[5:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte with a behavioural mode-0 slave that answers
// the previous byte (0x03 -> 0x02, anything else echoed) or a tied MISO level.
module tb_spi_master_byte;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 8;
  localparam int CS_HOLD  = 8;
  localparam int CS_IDLE  = 16;
  localparam int LOW_LEN  = CS_SETUP + 16 * CLK_DIV + CS_HOLD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, busy, SCK, MOSI, MISO, SSEL;
  logic [7:0] rx_data;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  spi_master_byte #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                    .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural slave
  logic       slave_en = 1'b0;
  logic       miso_tie = 1'b1;
  logic       slave_miso = 1'b0;
  logic [7:0] s_in = 8'h00;
  logic [7:0] s_out = 8'h00;
  logic [3:0] s_bits = 4'd0;
  logic       s_sck_p = 1'b0;
  logic       s_ssel_p = 1'b1;
  assign MISO = slave_en ? slave_miso : miso_tie;

  function automatic logic [7:0] slave_reply(input logic [7:0] b);
    return (b == 8'h03) ? 8'h02 : b;
  endfunction

  always @(posedge clk) begin
    if (SSEL) begin
      s_bits     <= 4'd0;
      slave_miso <= 1'b0;
    end else if (s_ssel_p) begin
      s_out      <= 8'h00;
      slave_miso <= 1'b0;
      s_bits     <= 4'd0;
    end else if (SCK && !s_sck_p) begin
      s_in   <= {s_in[6:0], MOSI};
      s_bits <= s_bits + 4'd1;
    end else if (!SCK && s_sck_p) begin
      if (s_bits == 4'd8) begin
        s_out      <= slave_reply(s_in);
        slave_miso <= slave_reply(s_in) >> 7;
        s_bits     <= 4'd0;
      end else begin
        slave_miso <= s_out[6];
        s_out      <= {s_out[6:0], 1'b0};
      end
    end
    s_sck_p  <= SCK;
    s_ssel_p <= SSEL;
  end

  // Bus monitor, sampled on the falling clock edge
  int         rises = 0, windows = 0, last_low = 0, low_cnt = 0, rx_count = 0;
  int         accepts = 0, mosi_bad = 0, align_bad = 0, ready_bad = 0;
  logic [7:0] rx_log [0:63];
  logic [7:0] mosi_word = 8'h00;
  logic       sck_p = 1'b0, ssel_p = 1'b1, mosi_p = 1'b0;

  always @(negedge clk) begin
    if (!SSEL) low_cnt++;
    if (SSEL && !ssel_p) begin
      last_low = low_cnt;
      low_cnt  = 0;
      windows++;
    end
    if (SCK && !sck_p) begin
      rises++;
      mosi_word = {mosi_word[6:0], MOSI};
    end
    if (SCK && (MOSI !== mosi_p)) mosi_bad++;
    if (rx_valid) begin
      rx_log[rx_count % 64] = rx_data;
      rx_count++;
      if (!(sck_p && !SCK)) align_bad++;
    end
    if (tx_valid && tx_ready) accepts++;
    if (tx_ready && SCK) ready_bad++;
    sck_p  = SCK;
    ssel_p = SSEL;
    mosi_p = MOSI;
  end

  // Driver tasks; every task starts and ends 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    while (!tx_ready && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL send_timeout: tx_ready never rose for byte %h", d);
    end
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !tx_ready) && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%b tx_ready=%b", busy, tx_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (SCK !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", SCK); end
    total++; if (MOSI !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
    total++; if (SSEL !== 1'b1) begin bad++; $display("FAIL reset_ssel: got %b want 1", SSEL); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rxv: got %b want 0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rxd: got %h want 00", rx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int r0 = rises, w0 = windows, x0 = rx_count;
    int n = 0, g = 0;
    slave_en = 1'b0; miso_tie = 1'b1;
    send_byte(8'h03, 1'b1);
    total++; if (SSEL !== 1'b0) begin bad++; $display("FAIL single_ssel_fall: got %b want 0", SSEL); end
    total++; if (MOSI !== 1'b0) begin bad++; $display("FAIL single_mosi_msb: got %b want 0", MOSI); end
    while (!SCK && n < 200) begin @(posedge clk); #1; n++; end
    total++; if (n !== CS_SETUP + CLK_DIV) begin bad++; $display("FAIL single_first_rise: got %0d want %0d", n, CS_SETUP + CLK_DIV); end
    n = 0;
    while (!SSEL && n < 1000) begin @(posedge clk); #1; n++; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_gap_busy: got %b want 1", busy); end
    while (!tx_ready && g < 1000) begin @(posedge clk); #1; g++; end
    total++; if (g !== CS_IDLE) begin bad++; $display("FAIL single_gap_len: got %0d want %0d", g, CS_IDLE); end
    total++; if (last_low !== LOW_LEN) begin bad++; $display("FAIL single_low_len: got %0d want %0d", last_low, LOW_LEN); end
    total++; if (rises - r0 !== 8) begin bad++; $display("FAIL single_rises: got %0d want 8", rises - r0); end
    total++; if (windows - w0 !== 1) begin bad++; $display("FAIL single_windows: got %0d want 1", windows - w0); end
    total++; if (mosi_word !== 8'h03) begin bad++; $display("FAIL single_mosi_bits: got %h want 03", mosi_word); end
    total++; if (rx_count - x0 !== 1) begin bad++; $display("FAIL single_rx_pulses: got %0d want 1", rx_count - x0); end
    total++; if (rx_log[x0 % 64] !== 8'hFF) begin bad++; $display("FAIL single_rx_data: got %h want ff", rx_log[x0 % 64]); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL single_rx_hold: got %h want ff", rx_data); end
  endtask

  task automatic test_slave_pair(input logic [7:0] b0, input logic [7:0] exp1, input string name);
    int w0 = windows, x0 = rx_count;
    slave_en = 1'b1;
    send_byte(b0, 1'b0);
    send_byte(8'h00, 1'b1);
    wait_idle();
    total++; if (windows - w0 !== 1) begin bad++; $display("FAIL %s_windows: got %0d want 1", name, windows - w0); end
    total++; if (rx_count - x0 !== 2) begin bad++; $display("FAIL %s_rx_pulses: got %0d want 2", name, rx_count - x0); end
    total++; if (rx_log[x0 % 64] !== 8'h00) begin bad++; $display("FAIL %s_rx0: got %h want 00", name, rx_log[x0 % 64]); end
    total++; if (rx_log[(x0 + 1) % 64] !== exp1) begin bad++; $display("FAIL %s_rx1: got %h want %h", name, rx_log[(x0 + 1) % 64], exp1); end
    slave_en = 1'b0;
  endtask

  task automatic test_hold_valid();
    int a0 = accepts, w0 = windows, x0 = rx_count;
    int n = 0;
    slave_en = 1'b1;
    tx_data = 8'hA5; tx_last = 1'b0; tx_valid = 1'b1;
    while (accepts - a0 < 2 && n < 3000) begin
      @(posedge clk); #1; n++;
      if (accepts - a0 == 1 && !tx_ready) tx_last = 1'b1;
    end
    tx_valid = 1'b0;
    if (n >= 3000) begin total++; bad++; $display("FAIL hold_timeout: accepts=%0d", accepts - a0); end
    wait_idle();
    total++; if (accepts - a0 !== 2) begin bad++; $display("FAIL hold_accepts: got %0d want 2", accepts - a0); end
    total++; if (windows - w0 !== 1) begin bad++; $display("FAIL hold_windows: got %0d want 1", windows - w0); end
    total++; if (rx_count - x0 !== 2) begin bad++; $display("FAIL hold_rx_pulses: got %0d want 2", rx_count - x0); end
    total++; if (rx_log[(x0 + 1) % 64] !== 8'hA5) begin bad++; $display("FAIL hold_rx1: got %h want a5", rx_log[(x0 + 1) % 64]); end
    total++; if (mosi_word !== 8'hA5) begin bad++; $display("FAIL hold_mosi_bits: got %h want a5", mosi_word); end
    total++; if (ready_bad !== 0) begin bad++; $display("FAIL hold_ready_in_byte: got %0d want 0", ready_bad); end
    slave_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int r0 = rises, x0;
    int n = 0;
    slave_en = 1'b0; miso_tie = 1'b1;
    send_byte(8'h81, 1'b1);
    while (rises - r0 < 3 && n < 1000) begin @(posedge clk); #1; n++; end
    x0 = rx_count;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (SSEL !== 1'b1) begin bad++; $display("FAIL abort_ssel: got %b want 1", SSEL); end
    total++; if (SCK !== 1'b0) begin bad++; $display("FAIL abort_sck: got %b want 0", SCK); end
    total++; if (MOSI !== 1'b0) begin bad++; $display("FAIL abort_mosi: got %b want 0", MOSI); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", tx_ready); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL abort_rxd: got %h want 00", rx_data); end
    repeat (40) @(posedge clk);
    #1;
    total++; if (rx_count !== x0) begin bad++; $display("FAIL abort_rx_pulse: got %0d want %0d", rx_count, x0); end
    // Normal transfer after the abort, MISO tied low
    miso_tie = 1'b0;
    x0 = rx_count;
    send_byte(8'h3C, 1'b1);
    wait_idle();
    total++; if (mosi_word !== 8'h3C) begin bad++; $display("FAIL after_mosi_bits: got %h want 3c", mosi_word); end
    total++; if (last_low !== LOW_LEN) begin bad++; $display("FAIL after_low_len: got %0d want %0d", last_low, LOW_LEN); end
    total++; if (rx_count - x0 !== 1) begin bad++; $display("FAIL after_rx_pulses: got %0d want 1", rx_count - x0); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL after_rxd: got %h want 00", rx_data); end
    miso_tie = 1'b1;
  endtask

  task automatic test_wait_next_delay();
    int w0 = windows, x0 = rx_count;
    int n = 0, quiet_bad = 0;
    slave_en = 1'b0; miso_tie = 1'b1;
    send_byte(8'h55, 1'b0);
    while (rx_count - x0 < 1 && n < 1000) begin @(posedge clk); #1; n++; end
    repeat (50) begin
      @(posedge clk); #1;
      if (SSEL !== 1'b0 || SCK !== 1'b0 || MOSI !== 1'b0) quiet_bad++;
    end
    total++; if (quiet_bad !== 0) begin bad++; $display("FAIL wait_quiet: got %0d bad cycles want 0", quiet_bad); end
    send_byte(8'hAA, 1'b1);
    total++; if (MOSI !== 1'b1) begin bad++; $display("FAIL wait_mosi_msb: got %b want 1", MOSI); end
    n = 0;
    while (!SCK && n < 200) begin @(posedge clk); #1; n++; end
    total++; if (n !== CLK_DIV) begin bad++; $display("FAIL wait_low_phase: got %0d want %0d", n, CLK_DIV); end
    wait_idle();
    total++; if (windows - w0 !== 1) begin bad++; $display("FAIL wait_windows: got %0d want 1", windows - w0); end
    total++; if (mosi_word !== 8'hAA) begin bad++; $display("FAIL wait_mosi_bits: got %h want aa", mosi_word); end
    total++; if (rx_count - x0 !== 2) begin bad++; $display("FAIL wait_rx_pulses: got %0d want 2", rx_count - x0); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL wait_rxd: got %h want ff", rx_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_slave_pair(8'h03, 8'h02, "cmd");
    test_slave_pair(8'h05, 8'h05, "echo");
    test_hold_valid();
    test_reset_mid();
    test_wait_next_delay();
    total++; if (mosi_bad !== 0) begin bad++; $display("FAIL mosi_stable_high: got %0d changes want 0", mosi_bad); end
    total++; if (align_bad !== 0) begin bad++; $display("FAIL rx_on_sck_fall: got %0d misaligned want 0", align_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
